// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear, count enable, flags the final iteration.
module multdiv_counter #(
    parameter int CW   = 6,
    parameter int LAST = 31
) (
    input  logic clk,
    input  logic aclr,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // High while the iteration about to run is the last one.
    assign last = (count == CW'(LAST));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide, one bit per cycle.
// Divider compiled in only when MULTDIV_DIV_EN is defined; otherwise DIV returns 0 with exception.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t state;
    op_t    op;
    logic   start;
    logic   iter_en;
    logic   last;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign iter_en = !start && (state == MUL || state == DIV);

    multdiv_counter #(
        .CW  (CW),
        .LAST(WIDTH - 1)
    ) u_counter (
        .clk (clk),
        .aclr(aclr),
        .clr (start),
        .en  (iter_en),
        .last(last)
    );

    // Booth product register: {accumulator, multiplier, q(-1)}.
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH-1:0]   mul_result;
    logic               mul_ovf;

    // One extra bit keeps the add exact for the most-negative multiplicand.
    always_comb begin
        booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        case (prod[1:0])
            2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            mcand <= '0;
            prod  <= '0;
        end else if (ctrl_MULT) begin
            mcand <= data_operandA;
            prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else if (!start && state == MUL) begin
            prod <= {booth_sum, prod[WIDTH:1]};
        end
    end

    assign mul_result = prod[WIDTH:1];
    assign mul_ovf    = !((&prod[2*WIDTH:WIDTH]) || !(|prod[2*WIDTH:WIDTH]));

    logic [WIDTH-1:0] div_result;
    logic             div_exc;

`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_neg;
    logic             div_zero;
    logic             div_ovf;

    assign a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            div_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (ctrl_DIV && !ctrl_MULT) begin
            quo      <= a_mag;
            rem      <= '0;
            divisor  <= b_mag;
            div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
        end else if (!start && state == DIV) begin
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    // Negating a zero quotient yields zero, so the sign fix needs no extra guard.
    always_comb begin
        if (div_zero) begin
            div_result = '0;
        end else if (div_ovf) begin
            div_result = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            div_result = div_neg ? -quo : quo;
        end
    end
    assign div_exc = div_zero | div_ovf;
`else
    assign div_result = '0;
    assign div_exc    = 1'b1;
`endif

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state          <= IDLE;
            op             <= OP_MUL;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                op    <= OP_MUL;
                state <= MUL;
            end else if (ctrl_DIV) begin
                op    <= OP_DIV;
`ifdef MULTDIV_DIV_EN
                state <= DIV;
`else
                state <= DONE;
`endif
            end else begin
                case (state)
                    MUL, DIV: begin
                        if (last) state <= DONE;
                    end
                    DONE: begin
                        state          <= IDLE;
                        data_resultRDY <= 1'b1;
                        if (op == OP_MUL) begin
                            data_result    <= mul_result;
                            data_exception <= mul_ovf;
                        end else begin
                            data_result    <= div_result;
                            data_exception <= div_exc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit (WIDTH=32); expectations follow MULTDIV_DIV_EN.
module tb_multdiv_unit;

    logic        clk;
    logic        aclr;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int tests;
    int fails;

    multdiv_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .aclr          (aclr),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start pulse; returns just after start edge 0.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input int exp_edge,
                            input logic [31:0] exp_res, input logic exp_exc);
        int n;
        n = 0;
        while (n < 200 && data_resultRDY !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_edge"}, n, exp_edge);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exp_exc});
        @(posedge clk);
        #1;
        check({tag, "_rdy_fall"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int exp_edge,
                          input logic [31:0] exp_res, input logic exp_exc);
        issue(m, d, a, b);
        wait_rdy(tag, exp_edge, exp_res, exp_exc);
    endtask

    initial begin
        int seen;
        tests         = 0;
        fails         = 0;
        aclr          = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'b0, data_exception}, 32'd0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clk);
        aclr = 1'b0;

        run_op("mul_7x-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 33, 32'hFFFF_FFD6, 1'b0);

        // Reset in the middle of a multiply clears outputs without a ready pulse.
        issue(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (14) @(posedge clk);
        #2;
        aclr = 1'b1;
        #1;
        check("aclr_result", data_result, 32'd0);
        check("aclr_exc", {31'b0, data_exception}, 32'd0);
        check("aclr_rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clk);
        aclr = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) seen++;
        end
        check("aclr_no_rdy", seen, 32'd0);
        run_op("mul_5x5", 1'b1, 1'b0, 32'd5, 32'd5, 33, 32'd25, 1'b0);

        run_op("mul_ovf_2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 33, 32'h0000_0000, 1'b1);
        run_op("mul_max_x1", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 33, 32'h7FFF_FFFF, 1'b0);
        run_op("mul_min_x-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
        run_op("mul_-1x-1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd1, 1'b0);
        run_op("both_ctrl_mul", 1'b1, 1'b1, 32'd6, 32'd7, 33, 32'd42, 1'b0);

`ifdef MULTDIV_DIV_EN
        run_op("div_-43/5", 1'b0, 1'b1, 32'hFFFF_FFD5, 32'd5, 33, 32'hFFFF_FFF8, 1'b0);
        run_op("div_100/0", 1'b0, 1'b1, 32'd100, 32'd0, 33, 32'd0, 1'b1);
        run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
        run_op("div_7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 1'b0);
        run_op("div_-3/7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 33, 32'd0, 1'b0);
`else
        run_op("div_off_20/3", 1'b0, 1'b1, 32'd20, 32'd3, 1, 32'd0, 1'b1);
`endif

        // Restart at edge 10 of a multiply: only the divide reports.
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        seen = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) seen++;
        end
        issue(1'b0, 1'b1, 32'd20, 32'd3);
`ifdef MULTDIV_DIV_EN
        wait_rdy("abort_div", 33, 32'd6, 1'b0);
`else
        wait_rdy("abort_div", 1, 32'd0, 1'b1);
`endif
        repeat (40) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) seen++;
        end
        check("abort_no_extra_rdy", seen, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed multiply/divide unit for the processor's execute stage. It accepts one operation per start pulse and runs a one-bit-per-cycle datapath. It returns a registered WIDTH-bit result with an exception flag and a one-cycle ready pulse. The writeback stage qualifies the register-file write enable with that pulse. The pipeline stalls from start until ready.

## Interface
- WIDTH, 32: operand and result width in bits; minimum 4.
- clk  in  1  clock; all state changes on the rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- ctrl_MULT  in  1  start a multiply; sampled on the rising edge of clk.
- ctrl_DIV  in  1  start a divide; sampled on the rising edge of clk.
- data_operandA  in  WIDTH  multiplicand or dividend, two's complement; sampled only on the start edge.
- data_operandB  in  WIDTH  multiplier or divisor, two's complement; sampled only on the start edge.
- data_result  out  WIDTH  product (low WIDTH bits) or quotient; registered.
- data_exception  out  1  overflow or divide-by-zero; registered.
- data_resultRDY  out  1  one-cycle pulse; result and exception valid.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset state: IDLE; data_result=0, data_exception=0, data_resultRDY=0; counter=0.
- Start edge: either ctrl high.
  - Operands are latched, the counter is cleared, and the FSM enters MUL or DIV.
  - If both ctrl_MULT and ctrl_DIV are high, MULT wins.
- Start while in MUL, DIV or DONE: the current operation is aborted without a ready pulse and restarts with the new operands.
- MUL: radix-2 Booth.
  - Product register is 2*WIDTH+1 bits.
  - One arithmetic shift per cycle for WIDTH cycles.
  - Exception = full 2*WIDTH product does not sign-extend from bit WIDTH-1.
  - Result = low WIDTH bits of the product.
- DIV: restoring division on magnitudes, one quotient bit per cycle for WIDTH cycles.
  - Quotient is truncated toward zero.
  - Quotient is negated when sign(A) ≠ sign(B) and the quotient is nonzero.
  - Divisor = 0: result=0, exception=1, full latency.
  - A = most-negative value and B = -1: result = most-negative value, exception=1.
- Counter reaches WIDTH → DONE. In DONE, data_result and data_exception are loaded and data_resultRDY=1 for exactly one cycle; then the FSM returns to IDLE.
- data_result and data_exception hold their values until the next DONE or aclr.
- Counter width: $clog2(WIDTH+1).

## Timing
- Start edge = edge 0. Iterations run on edges 1..WIDTH. Outputs update and RDY rises on edge WIDTH+1, and RDY falls on edge WIDTH+2.
- Latency: WIDTH+1 cycles, start to RDY. Throughput: one operation per WIDTH+2 cycles.
- A start on the same edge that RDY falls is accepted.
- ctrl pulses longer than one cycle restart the operation on every high edge. The upstream stage drives one-cycle pulses.
- aclr asserted mid-operation: immediate IDLE with all outputs 0, no RDY; the next start after release proceeds normally.

## Configuration
- MULTDIV_DIV_EN defined: the divider datapath and DIV state are compiled in.
- MULTDIV_DIV_EN undefined:
  - ctrl_DIV alone (ctrl_MULT low) goes straight to DONE. On edge 1: result=0, exception=1, RDY=1.
  - No divider logic is synthesized.
  - Multiply behaviour is unchanged.

## Structure
- Package multdiv_pkg holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - the operation enum (OP_MUL, OP_DIV);
  - the DEFAULT_WIDTH constant.
- Sub-module multdiv_counter: iteration counter with clear, enable and terminal-count output, on the same clk/aclr. The FSM and datapaths live in multdiv_unit.

## Test plan
- MULT 7 × -6 → edge 33: result 0xFFFFFFD6, exception 0, RDY high exactly one cycle.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. MULT 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0.
- DIV -43 / 5 → 0xFFFFFFF8 (-8), exception 0. DIV 100 / 0 → result 0, exception 1, RDY at edge 33.
- DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1. Without MULTDIV_DIV_EN: DIV 20 / 3 → result 0, exception 1, RDY at edge 1.
- MULT 3 × 4, then at edge 10 start DIV 20 / 3 → a single RDY, 33 edges after the second start, with result 6. The MULT completes with no RDY.
- aclr at edge 15 of MULT 5 × 5 → outputs 0 immediately and no RDY. A subsequent MULT 5 × 5 → 25 at edge 33 after its start.
